// File: rtl/cond_defs.sv
// Shared condition-code encodings and NZCV bit positions for the conditional-execution unit.
package cond_defs;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/condcheck.sv
// Combinational ARM condition-code evaluation against the registered NZCV flags.
module condcheck
  import cond_defs::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v, ge;

  assign n  = Flags[FLAG_N];
  assign z  = Flags[FLAG_Z];
  assign c  = Flags[FLAG_C];
  assign v  = Flags[FLAG_V];
  assign ge = (n == v);

  always_comb begin
    // NOTE: default assigned before the case so no path can infer a latch.
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ge;
      COND_LT: CondEx = ~ge;
      COND_GT: CondEx = ~z & ge;
      COND_LE: CondEx = z | ~ge;
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;  // COND_NV is reserved and never executes
    endcase
  end

endmodule

// File: rtl/condlogic_mc.sv
// Multicycle conditional-execution unit: NZCV register, delayed condition, gated writes.
// Optional execute/squash counters are enabled by defining CONDLOGIC_STATS_EN.
module condlogic_mc
  import cond_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        NextPC,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [3:0]  Flags
`ifdef CONDLOGIC_STATS_EN
  ,
  output logic [31:0] ExecCount,
  output logic [31:0] SquashCount
`endif
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_delayed_q, cond_ex_delayed_d;
  logic       cond_ex;
  logic [1:0] flag_write;

  condcheck u_condcheck (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  assign flag_write = FlagW & {2{cond_ex}};

  always_comb begin
    flags_d           = flags_q;
    cond_ex_delayed_d = cond_ex;
    if (flag_write[1]) flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
    if (flag_write[0]) flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q           <= 4'b0000;
      cond_ex_delayed_q <= 1'b0;
    end else begin
      flags_q           <= flags_d;
      cond_ex_delayed_q <= cond_ex_delayed_d;
    end
  end

  // Writes lag Decode, so the delayed condition belongs to the current instruction.
  assign PCWrite  = (PCS & cond_ex_delayed_q) | NextPC;
  assign RegWrite = RegW & cond_ex_delayed_q;
  assign MemWrite = MemW & cond_ex_delayed_q;
  assign Flags    = flags_q;

`ifdef CONDLOGIC_STATS_EN
  logic        sample_pending_q, sample_pending_d;
  logic [31:0] exec_count_q, exec_count_d;
  logic [31:0] squash_count_q, squash_count_d;

  always_comb begin
    sample_pending_d = IRWrite;
    exec_count_d     = exec_count_q;
    squash_count_d   = squash_count_q;
    if (sample_pending_q) begin
      if (cond_ex) exec_count_d   = exec_count_q + 32'd1;
      else         squash_count_d = squash_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_pending_q <= 1'b0;
      exec_count_q     <= 32'd0;
      squash_count_q   <= 32'd0;
    end else begin
      sample_pending_q <= sample_pending_d;
      exec_count_q     <= exec_count_d;
      squash_count_q   <= squash_count_d;
    end
  end

  assign ExecCount   = exec_count_q;
  assign SquashCount = squash_count_q;
`else
  logic unused_irwrite;
  assign unused_irwrite = IRWrite;
`endif

endmodule

// File: tb/tb_condlogic_mc.sv
// Directed self-checking bench for condlogic_mc; stats checks compile in with CONDLOGIC_STATS_EN.
module tb_condlogic_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  Cond, ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS, NextPC, RegW, MemW, IRWrite;
  logic        PCWrite, RegWrite, MemWrite;
  logic [3:0]  Flags;
`ifdef CONDLOGIC_STATS_EN
  logic [31:0] ExecCount, SquashCount;
`endif

  int checks = 0;
  int passes = 0;

  condlogic_mc dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags)
`ifdef CONDLOGIC_STATS_EN
    ,
    .ExecCount   (ExecCount),
    .SquashCount (SquashCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference condition table written directly from the architectural definitions.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic load_flags(input logic [3:0] f);
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
    tick();
    FlagW = 2'b00;
  endtask

  initial begin
    reset = 1'b1; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1; IRWrite = 1'b0;

    // Reset state
    tick();
    check("reset_flags", {28'd0, Flags}, 32'h0);
    check("reset_regwrite", {31'd0, RegWrite}, 32'd0);
    check("reset_memwrite", {31'd0, MemWrite}, 32'd0);
    check("reset_pcwrite", {31'd0, PCWrite}, 32'd1);
    reset = 1'b0; NextPC = 1'b0; MemW = 1'b0;
    tick();
    check("post_reset_regwrite", {31'd0, RegWrite}, 32'd1);

    // Full flag load, then EQ / NE
    load_flags(4'b0110);
    check("flags_0110", {28'd0, Flags}, 32'h6);
    Cond = 4'b0000; RegW = 1'b1;
    tick();
    check("eq_regwrite", {31'd0, RegWrite}, 32'd1);
    Cond = 4'b0001;
    tick();
    check("ne_regwrite", {31'd0, RegWrite}, 32'd0);

    // Independent flag halves
    load_flags(4'b0000);
    check("flags_cleared", {28'd0, Flags}, 32'h0);
    Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1111;
    tick();
    check("nz_half_only", {28'd0, Flags}, 32'hC);
    FlagW = 2'b01; ALUFlags = 4'b0011;
    tick();
    check("cv_half_only", {28'd0, Flags}, 32'hF);
    FlagW = 2'b00;

    // Failed condition blocks the flag write and the branch
    load_flags(4'b0000);
    Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b0100; PCS = 1'b1; NextPC = 1'b0;
    tick();
    check("squashed_flags", {28'd0, Flags}, 32'h0);
    check("squashed_pcwrite", {31'd0, PCWrite}, 32'd0);
    NextPC = 1'b1;
    #1;
    check("nextpc_ungated", {31'd0, PCWrite}, 32'd1);
    FlagW = 2'b00; PCS = 1'b0; NextPC = 1'b0;

    // Flag-setting instruction keeps its own writeback (EQ passes, then clears Z)
    load_flags(4'b0100);
    Cond = 4'b0000; RegW = 1'b1; FlagW = 2'b10; ALUFlags = 4'b0000;
    tick();
    check("selfset_flags", {28'd0, Flags}, 32'h0);
    check("selfset_regwrite", {31'd0, RegWrite}, 32'd1);
    FlagW = 2'b00;

    // Reset mid-instruction drops a pending gated write
    Cond = 4'b1110; MemW = 1'b1;
    tick();
    check("pre_reset_memwrite", {31'd0, MemWrite}, 32'd1);
    reset = 1'b1;
    tick();
    check("midreset_regwrite", {31'd0, RegWrite}, 32'd0);
    check("midreset_memwrite", {31'd0, MemWrite}, 32'd0);
    reset = 1'b0; MemW = 1'b0;

    // Condition sweep observed through RegWrite one cycle later
    RegW = 1'b1;
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        load_flags(f[3:0]);
        Cond = c[3:0];
        tick();
        check($sformatf("sweep_c%0d_f%0d", c, f), {31'd0, RegWrite},
              {31'd0, ref_cond(c[3:0], f[3:0])});
      end
    end

`ifdef CONDLOGIC_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("stats_reset_exec", ExecCount, 32'd0);
    check("stats_reset_squash", SquashCount, 32'd0);
    for (int i = 0; i < 5; i++) begin
      Cond = (i < 3) ? 4'b1110 : 4'b1111;
      IRWrite = 1'b1;
      tick();
      IRWrite = 1'b0;
      tick();
    end
    check("stats_exec", ExecCount, 32'd3);
    check("stats_squash", SquashCount, 32'd2);
    // Back-to-back strobes each sample once
    Cond = 4'b1110; IRWrite = 1'b1;
    tick();
    tick();
    IRWrite = 1'b0;
    tick();
    check("stats_back_to_back", ExecCount, 32'd5);
    force dut.exec_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.exec_count_q;
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    tick();
    check("stats_wrap", ExecCount, 32'd0);
    check("stats_squash_hold", SquashCount, 32'd2);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
